// File: rtl/axi_to_uart_s00.sv
// rtl/axi_to_uart_s00.sv - AXI4-Lite register file with a 4-byte 8N1 UART transmit sequencer
module axi_to_uart_s00 #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int CLKS_PER_BIT       = 868
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              uart_rxd,
    output logic                              uart_txd,
    output logic                              uart_clk_edge,
    output logic [2:0]                        o_SM_Main,
    output logic                              dbg_uart_write_en,
    output logic                              dbg_uart_writing,
    output logic [7:0]                        dbg_uart_write_data,
    output logic                              dbg_uart_write_finished,
    output logic [7:0]                        dbg_uart_write_count,
    output logic                              dbg_o_tx_active,
    output logic                              dbg_o_tx_serial,
    output logic                              dbg_o_tx_done
);

    localparam int          DW     = C_S_AXI_DATA_WIDTH;
    localparam logic [15:0] CPB_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        SM_IDLE    = 3'd0,
        SM_START   = 3'd1,
        SM_DATA    = 3'd2,
        SM_STOP    = 3'd3,
        SM_CLEANUP = 3'd4
    } sm_e;

    // AXI channel state
    logic          awready_q, awready_d, wready_q, wready_d;
    logic          bvalid_q, bvalid_d, aw_en_q, aw_en_d;
    logic          arready_q, arready_d, rvalid_q, rvalid_d;
    logic [3:0]    araddr_q, araddr_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] regs_q [0:7];
    logic [DW-1:0] regs_d [0:7];

    // Byte sequencer state
    logic          writing_q, writing_d, kick_q, kick_d;
    logic          wen_q, wen_d, finished_q, finished_d;
    logic [7:0]    wdata_q, wdata_d, count_q, count_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   txword_q, txword_d;

    // TX core state
    sm_e           state_q, state_d;
    logic [15:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;

    logic          wr_fire, trigger, bit_end, tx_done, in_frame, tx_serial;
    logic [3:0]    wr_idx;
    logic [DW-1:0] rd_word;

    assign wr_idx   = S_AXI_AWADDR[5:2];
    assign wr_fire  = S_AXI_AWVALID & S_AXI_WVALID & ~awready_q & aw_en_q;
    assign trigger  = wr_fire & (wr_idx == 4'd7) & ~writing_q;
    assign bit_end  = (clk_cnt_q == CPB_M1);
    assign in_frame = (state_q == SM_START) | (state_q == SM_DATA) | (state_q == SM_STOP);
    assign tx_done  = (state_q == SM_CLEANUP);

    always_comb begin
        rd_word = '0;
        if (araddr_q < 4'd8) begin
            rd_word = regs_q[araddr_q[2:0]];
        end else if (araddr_q == 4'd8) begin
            rd_word = {16'h0000, count_q, 7'h00, writing_q};
        end
    end

    always_comb begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        aw_en_d   = aw_en_q;
        bvalid_d  = bvalid_q;
        arready_d = S_AXI_ARVALID & ~arready_q & ~rvalid_q;
        araddr_d  = araddr_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        for (int r = 0; r < 8; r++) begin
            regs_d[r] = regs_q[r];
        end

        if (wr_fire) begin
            awready_d = 1'b1;
            wready_d  = 1'b1;
            aw_en_d   = 1'b0;
            if (wr_idx < 4'd8) begin
                for (int b = 0; b < DW/8; b++) begin
                    if (S_AXI_WSTRB[b]) begin
                        regs_d[wr_idx[2:0]][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
                    end
                end
            end
        end else if (bvalid_q & S_AXI_BREADY) begin
            aw_en_d = 1'b1;
        end

        if (awready_q & wready_q & ~bvalid_q) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q & S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        if (arready_d) begin
            araddr_d = S_AXI_ARADDR[5:2];
        end
        // Read data is sampled from the registers before any same-edge write lands
        if (arready_q & ~rvalid_q) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
        end else if (rvalid_q & S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_comb begin
        writing_d  = writing_q;
        kick_d     = 1'b0;
        wen_d      = 1'b0;
        finished_d = 1'b0;
        wdata_d    = wdata_q;
        count_d    = count_q;
        idx_d      = idx_q;
        txword_d   = txword_q;

        if (trigger) begin
            writing_d = 1'b1;
            count_d   = 8'd0;
            idx_d     = 2'd0;
            kick_d    = 1'b1;
            txword_d  = S_AXI_WDATA[31:0];
        end

        if (kick_q) begin
            wen_d = 1'b1;
            case (idx_q)
                2'd0:    wdata_d = txword_q[31:24];
                2'd1:    wdata_d = txword_q[23:16];
                2'd2:    wdata_d = txword_q[15:8];
                default: wdata_d = txword_q[7:0];
            endcase
        end

        if (tx_done & writing_q) begin
            count_d = count_q + 8'd1;
            if (idx_q == 2'd3) begin
                writing_d  = 1'b0;
                finished_d = 1'b1;
            end else begin
                idx_d  = idx_q + 2'd1;
                kick_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        tx_serial = 1'b1;

        case (state_q)
            SM_IDLE: begin
                clk_cnt_d = '0;
                bit_d     = '0;
                if (wen_q) begin
                    shreg_d = wdata_q;
                    state_d = SM_START;
                end
            end
            SM_START: begin
                tx_serial = 1'b0;
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = SM_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            SM_DATA: begin
                tx_serial = shreg_q[bit_q];
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = SM_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            SM_STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    state_d   = SM_CLEANUP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 16'd1;
                end
            end
            SM_CLEANUP: state_d = SM_IDLE;
            default:    state_d = SM_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESETN) begin
        if (S_AXI_ARESETN) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            aw_en_q    <= 1'b1;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            araddr_q   <= '0;
            rdata_q    <= '0;
            for (int r = 0; r < 8; r++) begin
                regs_q[r] <= '0;
            end
            writing_q  <= 1'b0;
            kick_q     <= 1'b0;
            wen_q      <= 1'b0;
            finished_q <= 1'b0;
            wdata_q    <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            txword_q   <= '0;
            state_q    <= SM_IDLE;
            clk_cnt_q  <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
        end else begin
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            aw_en_q    <= aw_en_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            araddr_q   <= araddr_d;
            rdata_q    <= rdata_d;
            for (int r = 0; r < 8; r++) begin
                regs_q[r] <= regs_d[r];
            end
            writing_q  <= writing_d;
            kick_q     <= kick_d;
            wen_q      <= wen_d;
            finished_q <= finished_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            txword_q   <= txword_d;
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;

    assign uart_txd                = tx_serial;
    assign uart_clk_edge           = in_frame & bit_end;
    assign o_SM_Main               = state_q;
    assign dbg_uart_write_en       = wen_q;
    assign dbg_uart_writing        = writing_q;
    assign dbg_uart_write_data     = wdata_q;
    assign dbg_uart_write_finished = finished_q;
    assign dbg_uart_write_count    = count_q;
    assign dbg_o_tx_active         = (state_q != SM_IDLE);
    assign dbg_o_tx_serial         = tx_serial;
    assign dbg_o_tx_done           = tx_done;

    logic unused_ok;
    assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, uart_rxd,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_to_uart_s00.sv
// tb/tb_axi_to_uart_s00.sv - randomized self-checking bench for axi_to_uart_s00
module tb_axi_to_uart_s00;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
    logic        arvalid = 1'b0, rready = 1'b1, rxd = 1'b1;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        uart_txd, uart_clk_edge;
    logic [2:0]  sm;
    logic        d_wen, d_writing, d_fin, d_active, d_serial, d_done;
    logic [7:0]  d_wdata, d_count;

    axi_to_uart_s00 #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6), .CLKS_PER_BIT(CPB)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .uart_rxd(rxd), .uart_txd(uart_txd), .uart_clk_edge(uart_clk_edge), .o_SM_Main(sm),
        .dbg_uart_write_en(d_wen), .dbg_uart_writing(d_writing), .dbg_uart_write_data(d_wdata),
        .dbg_uart_write_finished(d_fin), .dbg_uart_write_count(d_count),
        .dbg_o_tx_active(d_active), .dbg_o_tx_serial(d_serial), .dbg_o_tx_done(d_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_regs [0:7];
    logic [7:0]  m_count;
    logic        m_writing;

    int n_wen = 0, n_fin = 0, n_edge = 0;
    always @(negedge clk) begin
        if (d_wen === 1'b1) n_wen++;
        if (d_fin === 1'b1) n_fin++;
        if (uart_clk_edge === 1'b1) n_edge++;
    end

    // Line-level UART receiver sampling mid-bit
    logic [7:0] rx_bytes [0:255];
    int         rx_cnt = 0;
    int         frame_err = 0;
    initial begin
        logic [7:0] v;
        forever begin
            @(negedge uart_txd);
            repeat (CPB/2) @(posedge clk);
            #1;
            if (uart_txd !== 1'b0) frame_err++;
            for (int b = 0; b < 8; b++) begin
                repeat (CPB) @(posedge clk);
                #1;
                v[b] = uart_txd;
            end
            repeat (CPB) @(posedge clk);
            #1;
            if (uart_txd !== 1'b1) frame_err++;
            rx_bytes[rx_cnt % 256] = v;
            rx_cnt++;
        end
    end

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_count   = '0;
        m_writing = 1'b0;
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        if (idx < 8) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endfunction

    function automatic logic [31:0] model_read(input int idx);
        if (idx < 8) return m_regs[idx];
        if (idx == 8) return {16'h0, m_count, 7'h0, m_writing};
        return 32'h0;
    endfunction

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
        bit ok;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (awready === 1'b1) ok = 1;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 20 && ok && bvalid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        if (!ok || bvalid !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL write_handshake addr=%h awready=%b bvalid=%b expected handshake", a, awready, bvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
        bit ok;
        araddr = a; arvalid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk); #1;
            if (arready === 1'b1) ok = 1;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        for (int i = 0; i < 20 && ok && rvalid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        if (!ok || rvalid !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL read_handshake addr=%h arready=%b rvalid=%b expected handshake", a, arready, rvalid);
        end
        d = rdata;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_tests++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_axi got=%b expected=00000", {awready, wready, bvalid, arready, rvalid});
        end
        n_tests++;
        if (uart_txd !== 1'b1 || sm !== 3'd0 || d_serial !== 1'b1) begin
            n_fail++; $display("FAIL reset_tx txd=%b sm=%0d serial=%b expected 1 0 1", uart_txd, sm, d_serial);
        end
        n_tests++;
        if ({d_wen, d_writing, d_wdata, d_fin, d_count, d_active, d_done, uart_clk_edge} !== 22'h0) begin
            n_fail++; $display("FAIL reset_dbg got=%h expected=0",
                {d_wen, d_writing, d_wdata, d_fin, d_count, d_active, d_done, uart_clk_edge});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            axi_read(6'(i * 4), d);
            n_tests++;
            if (d !== 32'h0) begin
                n_fail++; $display("FAIL reset_reg%0d got=%h expected=00000000", i, d);
            end
        end
    endtask

    task automatic test_write_timing();
        awaddr = 6'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (awready !== 1'b1 || wready !== 1'b1 || bvalid !== 1'b0) begin
            n_fail++; $display("FAIL wr_ready aw=%b w=%b b=%b expected 1 1 0", awready, wready, bvalid);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n_tests++;
        if (awready !== 1'b0 || bvalid !== 1'b1 || bresp !== 2'b00) begin
            n_fail++; $display("FAIL wr_bvalid aw=%b b=%b resp=%b expected 0 1 00", awready, bvalid, bresp);
        end
        @(posedge clk); #1;
        n_tests++;
        if (bvalid !== 1'b0) begin
            n_fail++; $display("FAIL wr_bdone bvalid=%b expected 0", bvalid);
        end
        model_write(1, 32'hDEADBEEF, 4'hF);
    endtask

    task automatic test_read_timing();
        araddr = 6'h04; arvalid = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rd_arready ar=%b r=%b expected 1 0", arready, rvalid);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n_tests++;
        if (arready !== 1'b0 || rvalid !== 1'b1 || rdata !== 32'hDEADBEEF || rresp !== 2'b00) begin
            n_fail++; $display("FAIL rd_data ar=%b r=%b data=%h resp=%b expected 0 1 deadbeef 00",
                               arready, rvalid, rdata, rresp);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rd_done rvalid=%b expected 0", rvalid);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        axi_write(6'h04, 32'h11223344, 4'b0010);
        model_write(1, 32'h11223344, 4'b0010);
        axi_read(6'h04, d);
        n_tests++;
        if (d !== 32'hDEAD33EF || d !== m_regs[1]) begin
            n_fail++; $display("FAIL strobe got=%h expected=%h", d, m_regs[1]);
        end
    endtask

    task automatic test_random_regs();
        logic [31:0] d, w;
        logic [3:0]  s;
        int          idx;
        for (int i = 0; i < 30; i++) begin
            idx = $urandom_range(0, 15);
            if (idx == 7) idx = 0;
            w = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(6'(idx * 4), w, s);
            model_write(idx, w, s);
        end
        for (int i = 0; i < 16; i++) begin
            if (i != 7) begin
                axi_read(6'(i * 4), d);
                n_tests++;
                if (d !== model_read(i)) begin
                    n_fail++; $display("FAIL rand_reg%0d got=%h expected=%h", i, d, model_read(i));
                end
            end
        end
    endtask

    task automatic wait_finished(input int base_fin, output bit saw_data, output bit saw_cleanup);
        saw_data = 0; saw_cleanup = 0;
        for (int i = 0; i < 1000 && n_fin == base_fin; i++) begin
            @(posedge clk); #1;
            if (sm === 3'd2) saw_data = 1;
            if (sm === 3'd4) saw_cleanup = 1;
        end
        n_tests++;
        if (n_fin == base_fin) begin
            n_fail++; $display("FAIL tx_timeout finished=%0d expected a finished pulse", n_fin - base_fin);
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic check_frames(input string tag, input int base_rx, input logic [31:0] word);
        logic [7:0] e;
        n_tests++;
        if (rx_cnt - base_rx != 4) begin
            n_fail++; $display("FAIL %s_nbytes got=%0d expected=4", tag, rx_cnt - base_rx);
        end
        for (int i = 0; i < 4; i++) begin
            e = 8'(word >> (24 - 8 * i));
            n_tests++;
            if (rx_bytes[(base_rx + i) % 256] !== e) begin
                n_fail++; $display("FAIL %s_byte%0d got=%h expected=%h", tag, i, rx_bytes[(base_rx + i) % 256], e);
            end
        end
    endtask

    task automatic test_uart_tx();
        int base_rx, base_wen, base_fin, base_edge, base_err;
        bit saw_data, saw_cleanup;
        logic [31:0] d;
        base_rx = rx_cnt; base_wen = n_wen; base_fin = n_fin; base_edge = n_edge; base_err = frame_err;
        awaddr = 6'h1C; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (d_writing !== 1'b1 || d_wen !== 1'b0) begin
            n_fail++; $display("FAIL trig_writing writing=%b wen=%b expected 1 0", d_writing, d_wen);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n_tests++;
        if (d_wen !== 1'b1 || d_wdata !== 8'hDE) begin
            n_fail++; $display("FAIL trig_wen wen=%b data=%h expected 1 de", d_wen, d_wdata);
        end
        model_write(7, 32'hDEADBEEF, 4'hF);
        wait_finished(base_fin, saw_data, saw_cleanup);
        m_count = 8'd4;
        check_frames("tx", base_rx, 32'hDEADBEEF);
        n_tests++;
        if (n_wen - base_wen != 4 || n_fin - base_fin != 1 || n_edge - base_edge != 40) begin
            n_fail++; $display("FAIL tx_pulses wen=%0d fin=%0d edges=%0d expected 4 1 40",
                               n_wen - base_wen, n_fin - base_fin, n_edge - base_edge);
        end
        n_tests++;
        if (!saw_data || !saw_cleanup || frame_err != base_err) begin
            n_fail++; $display("FAIL tx_states data=%b cleanup=%b frame_err=%0d expected 1 1 0",
                               saw_data, saw_cleanup, frame_err - base_err);
        end
        n_tests++;
        if (d_count !== 8'd4 || d_writing !== 1'b0 || sm !== 3'd0) begin
            n_fail++; $display("FAIL tx_end count=%0d writing=%b sm=%0d expected 4 0 0", d_count, d_writing, sm);
        end
        axi_read(6'h20, d);
        n_tests++;
        if (d !== 32'h00000400 || d !== model_read(8)) begin
            n_fail++; $display("FAIL status got=%h expected=00000400", d);
        end
    endtask

    task automatic test_rewrite_mid();
        int base_rx, base_wen, base_fin;
        bit saw_data, saw_cleanup;
        logic [31:0] w1, w2, d;
        w1 = $urandom; w2 = $urandom;
        base_rx = rx_cnt; base_wen = n_wen; base_fin = n_fin;
        axi_write(6'h1C, w1, 4'hF);
        model_write(7, w1, 4'hF);
        repeat (20) @(posedge clk);
        #1;
        axi_write(6'h1C, w2, 4'hF);
        model_write(7, w2, 4'hF);
        wait_finished(base_fin, saw_data, saw_cleanup);
        check_frames("rewrite", base_rx, w1);
        n_tests++;
        if (n_wen - base_wen != 4 || n_fin - base_fin != 1) begin
            n_fail++; $display("FAIL rewrite_pulses wen=%0d fin=%0d expected 4 1", n_wen - base_wen, n_fin - base_fin);
        end
        axi_read(6'h1C, d);
        n_tests++;
        if (d !== m_regs[7]) begin
            n_fail++; $display("FAIL rewrite_reg got=%h expected=%h", d, m_regs[7]);
        end
    endtask

    task automatic test_reset_mid();
        int base_wen;
        logic [31:0] d;
        axi_write(6'h1C, $urandom, 4'hF);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if (uart_txd !== 1'b1 || sm !== 3'd0 || d_writing !== 1'b0 || d_active !== 1'b0 || d_count !== 8'd0) begin
            n_fail++; $display("FAIL reset_mid txd=%b sm=%0d writing=%b active=%b count=%0d expected 1 0 0 0 0",
                               uart_txd, sm, d_writing, d_active, d_count);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        base_wen = n_wen;
        repeat (60) @(posedge clk);
        #1;
        n_tests++;
        if (n_wen != base_wen || sm !== 3'd0 || uart_txd !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_idle wen=%0d sm=%0d txd=%b expected 0 0 1", n_wen - base_wen, sm, uart_txd);
        end
        axi_read(6'h1C, d);
        n_tests++;
        if (d !== model_read(7)) begin
            n_fail++; $display("FAIL reset_mid_reg got=%h expected=%h", d, model_read(7));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_timing();
        test_read_timing();
        test_strobe();
        test_random_regs();
        test_uart_tx();
        test_rewrite_mid();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/axi_to_uart_s00.md
# axi_to_uart_s00

AXI4-Lite slave that exposes a small register file and a byte-serial UART transmitter to the processing system. Software writes scratch/config registers and launches a 4-byte UART transmission by writing one trigger register. It sits between the AXI interconnect and the board UART pins, with debug outputs for ILA/waveform probing.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 6, AXI byte-address width (16 word registers)
- CLKS_PER_BIT, 868, S_AXI_ACLK cycles per UART bit (100 MHz / 115200)

Ports:
- S_AXI_ACLK  in  1  the single clock; all logic on rising edge
- S_AXI_ARESETN  in  1  one clock; reset is asynchronous and active-high (1 = reset)
- S_AXI_AWADDR/AWPROT/AWVALID  in  6/3/1; S_AXI_AWREADY out 1 — write address channel (AWPROT ignored)
- S_AXI_WDATA/WSTRB/WVALID  in  32/4/1; S_AXI_WREADY out 1 — write data channel
- S_AXI_BRESP  out 2, S_AXI_BVALID out 1; S_AXI_BREADY in 1 — write response
- S_AXI_ARADDR/ARPROT/ARVALID  in  6/3/1; S_AXI_ARREADY out 1 — read address (ARPROT ignored)
- S_AXI_RDATA out 32, S_AXI_RRESP out 2, S_AXI_RVALID out 1; S_AXI_RREADY in 1 — read data
- uart_rxd  in  1  UART receive line (unused; no logic)
- uart_txd  out  1  UART transmit line, idle high
- uart_clk_edge  out  1  one-cycle pulse at each bit-period boundary while transmitting
- o_SM_Main  out  3  TX state: 0 IDLE, 1 START, 2 DATA, 3 STOP, 4 CLEANUP
- dbg_uart_write_en  out 1  one-cycle pulse when a byte is handed to the TX core
- dbg_uart_writing  out 1  high from trigger accept until last byte done
- dbg_uart_write_data  out 8  byte currently handed to TX core
- dbg_uart_write_finished  out 1  one-cycle pulse after 4th byte's stop bit
- dbg_uart_write_count  out 8  bytes completed in current/last transfer
- dbg_o_tx_active / dbg_o_tx_serial / dbg_o_tx_done  out 1 each  TX core active, serial bit, done pulse

## Operation
- Word address = AxADDR[5:2]. Map: 0x00–0x18 reg0–reg6 R/W scratch; 0x1C TXDATA (R/W; write launches transfer); 0x20 STATUS RO: bit0 = writing, bits[15:8] = write_count; 0x24–0x3C read 0, writes ignored.
- Writes honor WSTRB per byte. BRESP/RRESP always 00 (OKAY).
- Write to 0x1C while idle: latch WDATA, start 4-byte transfer MSB byte first (WDATA[31:24] … [7:0]), write_count cleared to 0. Write to 0x1C while writing: register updated, no new transfer.
- TX core: 8N1, LSB first. IDLE (txd=1) → START (txd=0, CLKS_PER_BIT cycles) → DATA (8 bits) → STOP (txd=1) → CLEANUP (1 cycle, tx_done pulse) → IDLE. Sequencer loads next byte in cycle after tx_done; count increments on each tx_done; finished pulses with 4th done.
- Reset: all registers 0, all AXI ready/valid outputs 0, uart_txd=1, o_SM_Main=0, all dbg outputs 0 except dbg_o_tx_serial=1; reset mid-transfer aborts immediately.

## Timing
- Write: when AWVALID & WVALID & !AWREADY & aw_en, AWREADY and WREADY assert next cycle for exactly one cycle; register updated that same edge; BVALID asserts the following cycle, holds until BREADY; aw_en re-enables on B handshake.
- Read: ARREADY asserts one cycle after ARVALID seen (one-cycle pulse, ARADDR latched); RVALID+RDATA the cycle after, held until RREADY.
- Write-to-0x1C → dbg_uart_write_en: 1 cycle after register update. One byte = 10·CLKS_PER_BIT + 1 cycles.
- Simultaneous read and write allowed; a read returns pre-write value if same edge.

## Test plan
- Reset asserted 2 cycles → all outputs at reset values, uart_txd=1, o_SM_Main=0.
- AW+W to 0x04 data 0xDEADBEEF, WSTRB=1111, BREADY=1 → AWREADY=WREADY=1 second edge, BVALID next edge, BRESP=00.
- Read 0x04 → ARREADY at second edge, RVALID with RDATA=0xDEADBEEF next edge.
- Write 0x04 data 0x11223344 WSTRB=0010 over 0xDEADBEEF → readback 0xDEAD33EF.
- Write 0x1C 0xDEADBEEF, CLKS_PER_BIT=4 → txd frames 0xDE,0xAD,0xBE,0xEF (LSB first), count ends 4, finished pulse, STATUS=0x00000400.
- Write 0x1C again mid-transfer → no restart; reset mid-transfer → txd=1, SM IDLE immediately.
